// File: rtl/uart_tx_queue_pkg.sv
// Shared definitions for the UART transmit queue: launcher states and default widths
// kept in one place so the queue and the transmitter agree on DBIT.
package uart_tx_queue_pkg;

   localparam int unsigned DBIT_DEFAULT      = 8;
   localparam int unsigned ADDR_BITS_DEFAULT = 4;

   typedef enum logic {
      Q_IDLE = 1'b0,
      Q_WAIT = 1'b1
   } q_state_e;

endpackage

// File: rtl/uart_tx_queue_fifo.sv
// Circular byte FIFO feeding the UART launcher: pointers, occupancy counter,
// full/empty decode and a registered overflow pulse for dropped writes.
module tx_fifo
   import uart_tx_queue_pkg::*;
#(
   parameter int unsigned DBIT      = DBIT_DEFAULT,
   parameter int unsigned ADDR_BITS = ADDR_BITS_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr,
   input  logic [DBIT-1:0]      wr_data,
   input  logic                 rd,
   output logic [DBIT-1:0]      rd_data,
   output logic                 full,
   output logic                 empty,
   output logic [ADDR_BITS:0]   count,
   output logic                 overflow_tick
);

   localparam int unsigned        DEPTH    = 1 << ADDR_BITS;
   localparam logic [ADDR_BITS:0] FULL_CNT = {1'b1, {ADDR_BITS{1'b0}}};

   logic [DBIT-1:0]      mem_q [DEPTH];
   logic [ADDR_BITS-1:0] wp_q, wp_d;
   logic [ADDR_BITS-1:0] rp_q, rp_d;
   logic [ADDR_BITS:0]   cnt_q, cnt_d;
   logic                 ovf_q, ovf_d;
   logic                 push, pop;

   // full is decoded from the registered count, so a write while full is
   // rejected even when a pop frees a slot in the same cycle
   assign full  = (cnt_q == FULL_CNT);
   assign empty = (cnt_q == '0);
   assign push  = wr && !full;
   assign pop   = rd && !empty;

   always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q;
      ovf_d = wr && full;
      if (push) wp_d = wp_q + ADDR_BITS'(1);
      if (pop)  rp_d = rp_q + ADDR_BITS'(1);
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + (ADDR_BITS+1)'(1);
         2'b01:   cnt_d = cnt_q - (ADDR_BITS+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wp_q] <= wr_data;
   end

   assign rd_data       = mem_q[rp_q];
   assign count         = cnt_q;
   assign overflow_tick = ovf_q;

   cnt_bounded_a: assert property (@(posedge clk) disable iff (reset) cnt_q <= FULL_CNT);

endmodule

// File: rtl/uart_tx_queue.sv
// Transmit-side queue: buffers bytes in tx_fifo and launches one frame at a time
// into the UART transmitter, waiting for tx_done_tick between launches.
module uart_tx_queue
   import uart_tx_queue_pkg::*;
#(
   parameter int unsigned DBIT      = DBIT_DEFAULT,
   parameter int unsigned ADDR_BITS = ADDR_BITS_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr,
   input  logic [DBIT-1:0]      wr_data,
   output logic                 full,
   output logic                 empty,
   output logic [ADDR_BITS:0]   count,
   output logic                 overflow_tick,
   input  logic                 tx_done_tick,
   output logic                 tx_start,
   output logic [DBIT-1:0]      tx_din,
   output logic                 busy
);

   q_state_e        state_q;
   logic            tx_start_q;
   logic [DBIT-1:0] tx_din_q;
   logic            fifo_empty;
   logic            fifo_rd;
   logic [DBIT-1:0] fifo_rd_data;

   // pop in the same cycle the launch registers capture the head entry
   assign fifo_rd = (state_q == Q_IDLE) && !fifo_empty;

   tx_fifo #(
      .DBIT      (DBIT),
      .ADDR_BITS (ADDR_BITS)
   ) u_fifo (
      .clk           (clk),
      .reset         (reset),
      .wr            (wr),
      .wr_data       (wr_data),
      .rd            (fifo_rd),
      .rd_data       (fifo_rd_data),
      .full          (full),
      .empty         (fifo_empty),
      .count         (count),
      .overflow_tick (overflow_tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= Q_IDLE;
         tx_start_q <= 1'b0;
         tx_din_q   <= '0;
      end else begin
         case (state_q)
            Q_IDLE: begin
               if (!fifo_empty) begin
                  tx_din_q   <= fifo_rd_data;
                  tx_start_q <= 1'b1;
                  state_q    <= Q_WAIT;
               end else begin
                  tx_start_q <= 1'b0;
               end
            end
            Q_WAIT: begin
               tx_start_q <= 1'b0;
               if (tx_done_tick) state_q <= Q_IDLE;
            end
            default: begin
               tx_start_q <= 1'b0;
               state_q    <= Q_IDLE;
            end
         endcase
      end
   end

   assign empty    = fifo_empty;
   assign tx_start = tx_start_q;
   assign tx_din   = tx_din_q;
   assign busy     = (state_q == Q_WAIT);

   start_single_a: assert property (@(posedge clk) disable iff (reset) tx_start_q |=> !tx_start_q);
   start_busy_a:   assert property (@(posedge clk) disable iff (reset) tx_start_q |-> busy);

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed self-checking bench for uart_tx_queue with a hand-driven tx_done_tick.
module tb_uart_tx_queue;

   localparam int unsigned DBIT = 8;
   localparam int unsigned AB   = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr;
   logic [7:0]    wr_data;
   logic          full;
   logic          empty;
   logic [AB:0]   count;
   logic          overflow_tick;
   logic          tx_done_tick;
   logic          tx_start;
   logic [7:0]    tx_din;
   logic          busy;

   always #5 clk = ~clk;

   uart_tx_queue #(
      .DBIT      (DBIT),
      .ADDR_BITS (AB)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .wr            (wr),
      .wr_data       (wr_data),
      .full          (full),
      .empty         (empty),
      .count         (count),
      .overflow_tick (overflow_tick),
      .tx_done_tick  (tx_done_tick),
      .tx_start      (tx_start),
      .tx_din        (tx_din),
      .busy          (busy)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   int         viol     = 0;
   int         base;
   logic       busy_prev  = 1'b0;
   logic       start_prev = 1'b0;
   logic [7:0] launches[$];

   // launch log: every tx_start pulse, plus pulses that overlap a running frame
   always @(negedge clk) begin
      if (reset) begin
         busy_prev  = 1'b0;
         start_prev = 1'b0;
      end else begin
         if (tx_start) begin
            launches.push_back(tx_din);
            if (busy_prev || start_prev) viol++;
         end
         busy_prev  = busy;
         start_prev = tx_start;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] d);
      wr      = 1'b1;
      wr_data = d;
      tick();
      wr      = 1'b0;
   endtask

   task automatic pulse_done();
      tx_done_tick = 1'b1;
      tick();
      tx_done_tick = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
      check({tag, "_tx_din"},   32'(tx_din),   32'd0);
      check({tag, "_busy"},     32'(busy),     32'd0);
      check({tag, "_empty"},    32'(empty),    32'd1);
      check({tag, "_full"},     32'(full),     32'd0);
      check({tag, "_count"},    32'(count),    32'd0);
      check({tag, "_ovf"},      32'(overflow_tick), 32'd0);
   endtask

   initial begin
      reset        = 1'b1;
      wr           = 1'b0;
      wr_data      = 8'h00;
      tx_done_tick = 1'b0;
      repeat (3) tick();
      check_reset_outputs("rst");
      reset = 1'b0;

      // idle queue stays quiet
      repeat (10) tick();
      check("idle_empty", 32'(empty), 32'd1);
      check("idle_count", 32'(count), 32'd0);
      check("idle_busy",  32'(busy),  32'd0);
      check("idle_nolaunch", 32'(launches.size()), 32'd0);

      // single byte: tx_start two cycles after the write edge
      write_byte(8'hA5);
      check("a5_cnt1",    32'(count),    32'd1);
      check("a5_nostart", 32'(tx_start), 32'd0);
      tick();
      check("a5_start",  32'(tx_start), 32'd1);
      check("a5_din",    32'(tx_din),   32'hA5);
      check("a5_busy",   32'(busy),     32'd1);
      check("a5_cnt0",   32'(count),    32'd0);
      tick();
      check("a5_width",  32'(tx_start), 32'd0);
      check("a5_hold",   32'(tx_din),   32'hA5);
      repeat (3) tick();
      pulse_done();
      check("a5_idle",   32'(busy),     32'd0);
      tick();
      check("a5_nomore", 32'(tx_start), 32'd0);

      // burst 0x01..0x05
      base = launches.size();
      for (int k = 1; k <= 5; k++) write_byte(8'(k));
      check("burst_cnt", 32'(count), 32'd4);
      check("burst_busy", 32'(busy), 32'd1);
      for (int k = 2; k <= 5; k++) begin
         repeat (2) tick();
         pulse_done();
         check("burst_gap", 32'(tx_start), 32'd0);
         tick();
         check("burst_start", 32'(tx_start), 32'd1);
         check("burst_din",   32'(tx_din),   32'(k));
      end
      repeat (2) tick();
      pulse_done();
      repeat (3) tick();
      check("burst_n", 32'(launches.size() - base), 32'd5);
      for (int i = 0; i < 5; i++) check("burst_order", 32'(launches[base + i]), 32'(i + 1));
      check("burst_end_busy", 32'(busy), 32'd0);

      // fill to full and overflow with tx_done_tick held low
      base = launches.size();
      for (int i = 0; i < 18; i++) begin
         wr      = 1'b1;
         wr_data = 8'(i);
         tick();
         if (i == 16) begin
            check("fill_full",  32'(full),  32'd1);
            check("fill_count", 32'(count), 32'd16);
            check("fill_noovf", 32'(overflow_tick), 32'd0);
         end
         if (i == 17) begin
            check("ovf_tick",  32'(overflow_tick), 32'd1);
            check("ovf_count", 32'(count), 32'd16);
         end
      end
      wr = 1'b0;
      tick();
      check("ovf_pulse1", 32'(overflow_tick), 32'd0);
      check("ovf_keep",   32'(count), 32'd16);
      check("ovf_first_n",  32'(launches.size() - base), 32'd1);
      check("ovf_first_din", 32'(launches[base]), 32'h00);
      for (int k = 1; k <= 16; k++) begin
         pulse_done();
         tick();
         check("drain_start", 32'(tx_start), 32'd1);
         check("drain_din",   32'(tx_din),   32'(k));
         if (k == 1) begin
            check("drain_cnt15",  32'(count), 32'd15);
            check("drain_nofull", 32'(full),  32'd0);
         end
      end
      pulse_done();
      repeat (3) tick();
      check("drain_n",     32'(launches.size() - base), 32'd17);
      check("drain_empty", 32'(empty), 32'd1);
      check("drain_busy",  32'(busy),  32'd0);

      // reset mid-frame flushes the queued byte
      write_byte(8'h3C);
      write_byte(8'h3D);
      tick();
      check("midrst_busy", 32'(busy),  32'd1);
      check("midrst_cnt",  32'(count), 32'd1);
      reset = 1'b1;
      tick();
      check_reset_outputs("midrst");
      reset = 1'b0;
      tick();
      write_byte(8'h7E);
      tick();
      check("post_rst_start", 32'(tx_start), 32'd1);
      check("post_rst_din",   32'(tx_din),   32'h7E);
      repeat (2) tick();
      pulse_done();
      repeat (3) tick();
      check("post_rst_idle", 32'(busy), 32'd0);

      // write in the launch cycle at count 1
      write_byte(8'h42);
      write_byte(8'h55);
      check("c1_cnt",  32'(count),  32'd1);
      check("c1_din",  32'(tx_din), 32'h42);
      repeat (2) tick();
      pulse_done();
      check("c1_idle", 32'(busy), 32'd0);
      write_byte(8'h99);
      check("c1_launch", 32'(tx_start), 32'd1);
      check("c1_din55",  32'(tx_din),   32'h55);
      check("c1_keep",   32'(count),    32'd1);
      repeat (2) tick();
      pulse_done();
      tick();
      check("c1_next",  32'(tx_din),  32'h99);
      check("c1_cnt0",  32'(count),   32'd0);
      pulse_done();
      repeat (2) tick();
      check("c1_empty", 32'(empty), 32'd1);

      check("overlap_launch", 32'(viol), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Transmit-side buffer and launcher directly upstream of the UART transmitter. It accepts bytes from the system side (ALU result / interface logic) into a circular FIFO. It issues exactly one `tx_start` pulse per byte to the UART TX, then waits for the transmitter's `tx_done_tick` before launching the next byte. This decouples producers from the 9600-baud serial rate and keeps the transmitter from being restarted mid-frame.

## Interface
Parameters:
- `DBIT`, 8, data width; must match the transmitter's `DBIT`.
- `ADDR_BITS`, 4, FIFO address width; depth = 2^ADDR_BITS = 16 entries.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `wr`  in  1  write strobe, one byte per cycle.
- `wr_data`  in  DBIT  byte to enqueue.
- `full`  out  1  FIFO holds 2^ADDR_BITS entries.
- `empty`  out  1  FIFO holds 0 entries.
- `count`  out  ADDR_BITS+1  current occupancy.
- `overflow_tick`  out  1  one-cycle pulse when a write is dropped.
- `tx_done_tick`  in  1  end-of-frame pulse from the transmitter.
- `tx_start`  out  1  one-cycle launch pulse to the transmitter.
- `tx_din`  out  DBIT  byte presented to the transmitter; stable while `busy`.
- `busy`  out  1  a frame is launched and not yet completed.

## Operation
- Storage:
  - Circular buffer `mem[2^ADDR_BITS]`, write pointer `wp`, read pointer `rp`, both ADDR_BITS wide, wrapping modulo depth.
  - Occupancy counter `cnt` is ADDR_BITS+1 wide.
  - `full` = (`cnt` == 2^ADDR_BITS); `empty` = (`cnt` == 0). Both decode registered `cnt`.
- Write:
  - When `wr && !full`: store `wr_data` at `mem[wp]`, increment `wp`, increment `cnt`.
  - When `wr && full`: drop the byte and pulse `overflow_tick` in the next cycle. Pointers and contents are unchanged.
  - A write while full is rejected even if a pop occurs in the same cycle.
- Launcher FSM, states IDLE and WAIT:
  - IDLE, `!empty`: register `tx_din` <= `mem[rp]`, `tx_start` <= 1, increment `rp`, decrement `cnt`, go to WAIT.
  - IDLE, `empty`: hold. `tx_start` <= 0.
  - WAIT: `tx_start` <= 0. On `tx_done_tick` go to IDLE, otherwise hold.
- Simultaneous write and pop in one cycle: `cnt` unchanged, both pointers advance. This applies at any non-full occupancy, including `cnt` == 1.
- `tx_done_tick` while in IDLE is ignored.
- `busy` = (state == WAIT).
- `count` = `cnt`.

## Timing
- Reset values:
  - state IDLE, `wp` = `rp` = 0, `cnt` = 0.
  - `full` 0, `empty` 1, `count` 0.
  - `tx_start` 0, `tx_din` 0, `busy` 0, `overflow_tick` 0.
  - Memory contents are not reset.
- Reset mid-frame flushes the queue and returns to IDLE. The transmitter shares `reset`, so no partial-frame recovery is required.
- Latency from write to launch: `wr` sampled at edge N into an empty, idle queue gives `cnt` = 1 after N. `tx_start` is high in the cycle after edge N+1, i.e. 2 cycles.
- `tx_start` is exactly one cycle wide. `tx_din` is valid in that same cycle and holds until the next launch.
- Back-to-back frames: `tx_done_tick` sampled at edge D gives IDLE after D and the next `tx_start` high after D+1. The transmitter is already in its IDLE state by then, so no launch is lost.
- `full`, `empty` and `count` update one cycle after the accepted write or pop.

## Structure
- Shared package / include: FSM state encodings (`Q_IDLE`, `Q_WAIT`), and the default `DBIT` so the queue and transmitter agree.
- One sub-module: `tx_fifo` (storage, pointers, `cnt`, `full`/`empty`, `overflow_tick`) with a `rd` pop input.
- The top-level `uart_tx_queue` holds the launcher FSM and the `tx_start`/`tx_din` registers.

## Test plan
- Reset, then idle 10 cycles -> `empty` = 1, `count` = 0, `tx_start` never asserted, `busy` = 0.
- Write 0xA5 into the empty queue at cycle N -> single `tx_start` pulse 2 cycles later with `tx_din` = 0xA5. Paired with a real `uart_tx` (SB_TICK = 16), the serial line shows start bit, 1,0,1,0,0,1,0,1 LSB-first, stop bit.
- Burst-write 0x01..0x05 on consecutive cycles -> exactly 5 `tx_start` pulses in order 0x01..0x05. Each pulse comes 2 cycles after the previous `tx_done_tick`, and none occurs while `busy`.
- Hold `tx_done_tick` low and write 18 bytes 0x00..0x11:
  - First byte launches; the 16 following fill the queue to `full` = 1, `count` = 16.
  - The 18th byte (0x11) is dropped with an `overflow_tick` pulse.
  - Subsequent `tx_done_tick`s drain 0x01..0x10 in order.
- Write 0x3C, then assert `reset` while `busy` mid-frame -> all outputs return to reset values. A subsequent write of 0x7E launches 0x7E, not 0x3C.
- With `count` = 1 and the FSM launching, assert `wr` (0x99) in the launch cycle -> `count` stays 1 and 0x99 is the next byte launched.
